// File: rtl/rambus_pkg.sv
// Shared types and bus constants for the rambus Wishbone initiators.
package rambus_pkg;

  localparam int RAMBUS_ADR_W = 10;
  localparam int RAMBUS_DAT_W = 32;
  localparam logic [3:0] SEL_ALL = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    ABORT = 2'd3
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, flush, and same-cycle push/pop.
// The head word reads as zero while the FIFO is empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage has no reset; the count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/rambus_wb_reader.sv
// Wishbone classic read initiator: fetches a word range from the OpenRAM
// port B and streams it out through a prefetch FIFO, one-shot or looping.
module rambus_wb_reader
  import rambus_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int ACK_TIMEOUT    = 255,
  parameter int RAM_ADDR_WIDTH = 8
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      loop,
  input  logic [RAM_ADDR_WIDTH-1:0] start_addr,
  input  logic [RAM_ADDR_WIDTH-1:0] end_addr,
  output logic                      rambus_wb_clk_o,
  output logic                      rambus_wb_rst_o,
  output logic                      rambus_wb_stb_o,
  output logic                      rambus_wb_cyc_o,
  output logic                      rambus_wb_we_o,
  output logic [3:0]                rambus_wb_sel_o,
  output logic [RAMBUS_DAT_W-1:0]   rambus_wb_dat_o,
  output logic [RAMBUS_ADR_W-1:0]   rambus_wb_adr_o,
  input  logic                      rambus_wb_ack_i,
  input  logic [RAMBUS_DAT_W-1:0]   rambus_wb_dat_i,
  output logic [RAMBUS_DAT_W-1:0]   sample_data,
  output logic                      sample_valid,
  input  logic                      sample_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int          CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

  state_e                    state_q, state_d;
  logic                      stb_q, stb_d;
  logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RAM_ADDR_WIDTH-1:0] first_q, first_d;
  logic [RAM_ADDR_WIDTH-1:0] last_q, last_d;
  logic                      loop_q, loop_d;
  logic                      err_q, err_d;
  logic                      done_q, done_d;
  logic [15:0]               tmo_q, tmo_d;

  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_flush;
  logic                      fifo_empty;
  logic [CNT_W-1:0]          fifo_count;
  logic                      ack_seen;
  logic                      timed_out;

  sync_fifo #(
    .WIDTH (RAMBUS_DAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .flush (fifo_flush),
    .push  (fifo_push),
    .din   (rambus_wb_dat_i),
    .pop   (fifo_pop),
    .dout  (sample_data),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign sample_valid = !fifo_empty;
  assign fifo_pop     = sample_valid && sample_ready;

  // Only an ack that lands while our strobe is up belongs to us; late acks are dropped.
  assign ack_seen  = stb_q && rambus_wb_ack_i;
  assign timed_out = stb_q && !rambus_wb_ack_i && (tmo_q == TMO_LAST);

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    stb_d      = stb_q;
    addr_d     = addr_q;
    first_d    = first_q;
    last_d     = last_q;
    loop_d     = loop_q;
    err_d      = err_q;
    done_d     = 1'b0;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    tmo_d      = (stb_q && !rambus_wb_ack_i) ? tmo_q + 16'd1 : 16'd0;

    unique case (state_q)
      IDLE: begin
        if (stop) begin
          fifo_flush = 1'b1;
        end else if (start) begin
          first_d = start_addr;
          last_d  = end_addr;
          loop_d  = loop;
          addr_d  = start_addr;
          err_d   = 1'b0;
          stb_d   = 1'b1;
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (timed_out) begin
          stb_d      = 1'b0;
          err_d      = 1'b1;
          fifo_flush = 1'b1;
          state_d    = IDLE;
        end else if (stop) begin
          fifo_flush = 1'b1;
          if (stb_q && !rambus_wb_ack_i) begin
            state_d = ABORT;
          end else begin
            stb_d   = 1'b0;
            state_d = IDLE;
          end
        end else if (ack_seen) begin
          fifo_push = 1'b1;
          stb_d     = 1'b0;
          if (addr_q == last_q) begin
            if (loop_q) addr_d  = first_q;
            else        state_d = DRAIN;
          end else begin
            addr_d = addr_q + RAM_ADDR_WIDTH'(1);
          end
        end else if (!stb_q && (fifo_count < CNT_W'(FIFO_DEPTH))) begin
          // The count cannot rise while a transfer is pending, so this check cannot overflow.
          stb_d = 1'b1;
        end
      end

      DRAIN: begin
        if (stop) begin
          fifo_flush = 1'b1;
          state_d    = IDLE;
        end else if (fifo_empty) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      ABORT: begin
        fifo_flush = 1'b1;
        if (ack_seen || timed_out) begin
          stb_d   = 1'b0;
          err_d   = err_q || timed_out;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      stb_q   <= 1'b0;
      addr_q  <= '0;
      first_q <= '0;
      last_q  <= '0;
      loop_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      addr_q  <= addr_d;
      first_q <= first_d;
      last_q  <= last_d;
      loop_q  <= loop_d;
      err_q   <= err_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  assign rambus_wb_clk_o = wb_clk_i;
  assign rambus_wb_rst_o = ~wb_rst_ni;
  assign rambus_wb_stb_o = stb_q;
  assign rambus_wb_cyc_o = stb_q;
  assign rambus_wb_we_o  = 1'b0;
  assign rambus_wb_sel_o = SEL_ALL;
  assign rambus_wb_dat_o = '0;
  assign rambus_wb_adr_o = RAMBUS_ADR_W'({addr_q, 2'b00});

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_rambus_wb_reader.sv
// Self-checking bench: RAM responder, output monitor, table-driven runs against
// a range model, plus hand sequences for backpressure, loop, timeout and stop.
module tb_rambus_wb_reader;

  localparam int DEPTH = 4;

  logic        clk, rst_n;
  logic        start, stop, loop, sample_ready;
  logic [7:0]  start_addr, end_addr;
  logic        wb_clk, wb_rst, stb, cyc, we, ack;
  logic [3:0]  sel;
  logic [31:0] dat_o, dat_i, sample_data;
  logic [9:0]  adr;
  logic        sample_valid, busy, done, err;

  rambus_wb_reader dut (
    .wb_clk_i        (clk),
    .wb_rst_ni       (rst_n),
    .start           (start),
    .stop            (stop),
    .loop            (loop),
    .start_addr      (start_addr),
    .end_addr        (end_addr),
    .rambus_wb_clk_o (wb_clk),
    .rambus_wb_rst_o (wb_rst),
    .rambus_wb_stb_o (stb),
    .rambus_wb_cyc_o (cyc),
    .rambus_wb_we_o  (we),
    .rambus_wb_sel_o (sel),
    .rambus_wb_dat_o (dat_o),
    .rambus_wb_adr_o (adr),
    .rambus_wb_ack_i (ack),
    .rambus_wb_dat_i (dat_i),
    .sample_data     (sample_data),
    .sample_valid    (sample_valid),
    .sample_ready    (sample_ready),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Controls owned by the main sequence, read by the responder.
  bit rand_delay = 1'b0;
  bit never_ack  = 1'b0;
  bit manual     = 1'b0;
  bit manual_req = 1'b0;

  // Observations owned by the responder and monitor.
  logic [31:0] ram [256];
  logic [9:0]  adr_log [$];
  logic [31:0] out_q [$];
  int          done_cnt = 0;
  int          ack_cnt  = 0;

  int out_base, adr_base, done_base, ack_base;

  typedef struct {
    logic [7:0] s;
    logic [7:0] e;
    int         exp_len;
    bit         rnd_ready;
    bit         rnd_delay;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: a run visits start, start+1, ... end modulo 256.
  function automatic int run_len(input logic [7:0] s, input logic [7:0] e);
    return ((int'(e) - int'(s) + 256) % 256) + 1;
  endfunction

  function automatic logic [7:0] nth_addr(input logic [7:0] s, input int i);
    return 8'((int'(s) + i) % 256);
  endfunction

  // Wishbone RAM slave: acks after 0..3 wait cycles, or never, or on request.
  initial begin
    int wcnt;
    int cur_delay;
    wcnt = 0;
    cur_delay = 0;
    ack = 1'b0;
    dat_i = '0;
    for (int i = 0; i < 256; i++) ram[i] = 32'hA500_0000 + 32'(i);
    forever begin
      @(negedge clk);
      #1;
      if (ack) begin
        ack = 1'b0;
        wcnt = 0;
      end else if (stb && manual) begin
        if (manual_req) begin
          ack = 1'b1;
          dat_i = ram[adr[9:2]];
          adr_log.push_back(adr);
        end
      end else if (stb && !never_ack) begin
        if (wcnt >= (rand_delay ? cur_delay : 0)) begin
          ack = 1'b1;
          dat_i = ram[adr[9:2]];
          adr_log.push_back(adr);
          cur_delay = int'($urandom_range(0, 3));
        end else begin
          wcnt++;
        end
      end else if (!stb) begin
        wcnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (sample_valid && sample_ready) out_q.push_back(sample_data);
      if (done) done_cnt++;
      if (stb && ack) ack_cnt++;
    end
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  task automatic mark();
    out_base  = out_q.size();
    adr_base  = adr_log.size();
    done_base = done_cnt;
    ack_base  = ack_cnt;
  endtask

  task automatic pulse_start(input logic [7:0] s, input logic [7:0] e, input logic l);
    @(negedge clk);
    start_addr = s;
    end_addr   = e;
    loop       = l;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic drain_and_check(input logic [7:0] s, input logic [7:0] e,
                                 input int exp_len, input bit rnd_ready, input string tag);
    int n;
    int got;
    n = 0;
    while (done_cnt == done_base && n < 10 * exp_len + 100) begin
      @(negedge clk);
      sample_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #3;
      n++;
    end
    @(negedge clk);
    #3;
    check({tag, "_one_done"}, 32'(done_cnt - done_base), 32'd1);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_valid_low"}, 32'(sample_valid), 32'd0);
    check({tag, "_err_low"}, 32'(err), 32'd0);
    got = out_q.size() - out_base;
    check({tag, "_word_count"}, 32'(got), 32'(exp_len));
    check({tag, "_fetch_count"}, 32'(adr_log.size() - adr_base), 32'(exp_len));
    for (int i = 0; i < exp_len && i < got; i++)
      check($sformatf("%s_word[%0d]", tag, i), out_q[out_base + i],
            32'hA500_0000 + 32'(nth_addr(s, i)));
    for (int i = 0; i < exp_len && i < adr_log.size() - adr_base; i++)
      check($sformatf("%s_adr[%0d]", tag, i), 32'(adr_log[adr_base + i]),
            32'({nth_addr(s, i), 2'b00}));
  endtask

  initial begin
    int viol, bad, pops, acks, fifo_now, hi;
    logic [7:0] rs, re;

    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    loop = 1'b0;
    start_addr = '0;
    end_addr = '0;
    sample_ready = 1'b0;

    // Reset state and constant bus fields.
    repeat (2) @(negedge clk);
    #3;
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_cyc", 32'(cyc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_adr", 32'(adr), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_data", sample_data, 32'd0);
    check("rst_bus_reset_high", 32'(wb_rst), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    check("bus_reset_low", 32'(wb_rst), 32'd0);
    check("bus_clk_follows", 32'(wb_clk), 32'(clk));
    check("we_const", 32'(we), 32'd0);
    check("sel_const", 32'(sel), 32'hF);
    check("dat_o_const", dat_o, 32'd0);

    // Start-to-strobe and ack-to-valid latency on a single-word run.
    mark();
    sample_ready = 1'b1;
    pulse_start(8'd4, 8'd4, 1'b0);
    #3;
    check("lat_stb_next_cycle", 32'(stb), 32'd1);
    check("lat_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #3;
    check("lat_valid_after_ack", 32'(sample_valid), 32'd1);
    check("lat_data_after_ack", sample_data, 32'hA500_0004);
    drain_and_check(8'd4, 8'd4, 1, 1'b0, "lat");

    // Table-driven one-shot runs, then randomized ranges.
    vecs.push_back('{s: 8'd4,   e: 8'd7,   exp_len: 4,   rnd_ready: 1'b0, rnd_delay: 1'b0});
    vecs.push_back('{s: 8'd254, e: 8'd1,   exp_len: 4,   rnd_ready: 1'b0, rnd_delay: 1'b0});
    vecs.push_back('{s: 8'd9,   e: 8'd9,   exp_len: 1,   rnd_ready: 1'b1, rnd_delay: 1'b1});
    vecs.push_back('{s: 8'd0,   e: 8'd15,  exp_len: 16,  rnd_ready: 1'b1, rnd_delay: 1'b1});
    vecs.push_back('{s: 8'd128, e: 8'd127, exp_len: 256, rnd_ready: 1'b0, rnd_delay: 1'b1});
    for (int k = 0; k < 6; k++) begin
      rs = 8'($urandom_range(0, 255));
      re = nth_addr(rs, int'($urandom_range(0, 39)));
      vecs.push_back('{s: rs, e: re, exp_len: run_len(rs, re), rnd_ready: 1'b1, rnd_delay: 1'b1});
    end
    for (int v = 0; v < vecs.size(); v++) begin
      mark();
      rand_delay = vecs[v].rnd_delay;
      sample_ready = 1'b1;
      pulse_start(vecs[v].s, vecs[v].e, 1'b0);
      #3;
      check($sformatf("v%0d_stb_after_start", v), 32'(stb), 32'd1);
      drain_and_check(vecs[v].s, vecs[v].e, vecs[v].exp_len, vecs[v].rnd_ready,
                      $sformatf("v%0d", v));
    end

    // Backpressure: only DEPTH fetches while stalled, then all 16 in order.
    mark();
    rand_delay = 1'b0;
    @(negedge clk);
    sample_ready = 1'b0;
    pulse_start(8'd0, 8'd15, 1'b0);
    repeat (40) @(negedge clk);
    #3;
    check("bp_fetches", 32'(ack_cnt - ack_base), 32'(DEPTH));
    check("bp_cyc_low", 32'(cyc), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    check("bp_head", sample_data, 32'hA500_0000);
    drain_and_check(8'd0, 8'd15, 16, 1'b0, "bp");

    // Looping single word with a 1-in-3 consumer.
    mark();
    rand_delay = 1'b1;
    viol = 0;
    pulse_start(8'd9, 8'd9, 1'b1);
    for (int c = 0; c < 3000 && (out_q.size() - out_base) < 50; c++) begin
      @(negedge clk);
      sample_ready = (c % 3 == 0);
      #3;
      fifo_now = (ack_cnt - ack_base - int'(stb && ack))
               - (out_q.size() - out_base - int'(sample_valid && sample_ready));
      if (cyc && fifo_now >= DEPTH) viol++;
      if (fifo_now > DEPTH || fifo_now < 0) viol++;
    end
    pops = out_q.size() - out_base;
    acks = ack_cnt - ack_base;
    bad = 0;
    for (int i = 0; i < pops; i++) if (out_q[out_base + i] !== 32'hA500_0009) bad++;
    check("loop_enough_pops", 32'(pops >= 50), 32'd1);
    check("loop_all_word9", 32'(bad), 32'd0);
    check("loop_cyc_when_full", 32'(viol), 32'd0);
    check("loop_balance", 32'((acks - pops) >= 0 && (acks - pops) <= DEPTH), 32'd1);
    check("loop_no_done", 32'(done_cnt - done_base), 32'd0);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    for (int c = 0; c < 20 && busy; c++) @(negedge clk);
    #3;
    check("loop_stop_idle", 32'(busy), 32'd0);
    check("loop_stop_flushed", 32'(sample_valid), 32'd0);

    // Ack timeout: strobe held exactly 255 cycles, then error and idle.
    mark();
    never_ack = 1'b1;
    sample_ready = 1'b1;
    hi = 0;
    pulse_start(8'd30, 8'd31, 1'b0);
    for (int c = 0; c < 400; c++) begin
      #3;
      if (!stb) break;
      hi++;
      @(negedge clk);
    end
    check("tmo_stb_cycles", 32'(hi), 32'd255);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_valid", 32'(sample_valid), 32'd0);
    check("tmo_cyc", 32'(cyc), 32'd0);
    never_ack = 1'b0;
    mark();
    pulse_start(8'd30, 8'd30, 1'b0);
    #3;
    check("tmo_restart_clears_err", 32'(err), 32'd0);
    drain_and_check(8'd30, 8'd30, 1, 1'b0, "tmo_restart");

    // Stop during a bus cycle, ack two cycles later: word discarded.
    mark();
    manual = 1'b1;
    pulse_start(8'd40, 8'd50, 1'b0);
    #3;
    check("abort_stb_up", 32'(stb), 32'd1);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    #3;
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_stb_held", 32'(stb), 32'd1);
    @(negedge clk);
    manual_req = 1'b1;
    @(negedge clk);
    manual_req = 1'b0;
    #3;
    check("abort_stb_dropped", 32'(stb), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    #3;
    check("abort_fifo_empty", 32'(sample_valid), 32'd0);
    check("abort_no_output", 32'(out_q.size() - out_base), 32'd0);
    check("abort_no_done", 32'(done_cnt - done_base), 32'd0);
    manual = 1'b0;

    // Start and stop together: stop wins.
    mark();
    @(negedge clk);
    start_addr = 8'd60;
    end_addr = 8'd61;
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    #3;
    check("ss_busy", 32'(busy), 32'd0);
    check("ss_stb", 32'(stb), 32'd0);
    repeat (3) @(negedge clk);
    #3;
    check("ss_no_fetch", 32'(ack_cnt - ack_base), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
